// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a busy scoreboard for hazard detection.
// Optional write-through read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned HAS_ZERO = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    RegWrite,
    input  logic [AW-1:0]           WriteRegister,
    input  logic [WIDTH-1:0]        WriteData,
    input  logic [NUM_RD*AW-1:0]    ReadRegister,
    output logic [NUM_RD*WIDTH-1:0] ReadData,
    input  logic                    IssueEn,
    input  logic [AW-1:0]           IssueRegister,
    output logic [DEPTH-1:0]        Busy,
    output logic [AW:0]             BusyCount,
    output logic                    WriteUnexpected
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;
    logic             unexp_q, unexp_d;
    logic             write_ok, issue_ok;
    logic             cnt_inc, cnt_dec;

    assign write_ok = RegWrite && !((HAS_ZERO != 0) && (WriteRegister == ZERO_IDX));
    assign issue_ok = IssueEn && !((HAS_ZERO != 0) && (IssueRegister == ZERO_IDX));

    // Issue supersedes a same-cycle write to the same register.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (issue_ok && (IssueRegister == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (write_ok && (WriteRegister == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_inc    = issue_ok && !busy_q[IssueRegister];
        cnt_dec    = write_ok && busy_q[WriteRegister] &&
                     !(issue_ok && (IssueRegister == WriteRegister));
        busy_cnt_d = busy_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        unexp_d    = write_ok && !busy_q[WriteRegister];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
            unexp_q    <= 1'b0;
        end else begin
            if (write_ok) begin
                regs_q[WriteRegister] <= WriteData;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            unexp_q    <= unexp_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    rd_addr;
        logic [WIDTH-1:0] rd_data;

        assign rd_addr = ReadRegister[p*AW +: AW];

        always_comb begin
            rd_data = regs_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
            // write_ok already excludes the zero register, so it still reads 0.
            if (write_ok && (WriteRegister == rd_addr)) begin
                rd_data = WriteData;
            end
`endif
            if ((HAS_ZERO != 0) && (rd_addr == ZERO_IDX)) begin
                rd_data = '0;
            end
        end

        assign ReadData[p*WIDTH +: WIDTH] = rd_data;
    end

    assign Busy            = busy_q;
    assign BusyCount       = busy_cnt_q;
    assign WriteUnexpected = unexp_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (3 read ports); expectations queued at drive time, checked after.
module tb_regfile_mp;

    localparam int W  = 64;
    localparam int D  = 32;
    localparam int NR = 3;
    localparam int A  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWrite;
    logic [A-1:0]    WriteRegister;
    logic [W-1:0]    WriteData;
    logic [NR*A-1:0] ReadRegister;
    logic [NR*W-1:0] ReadData;
    logic            IssueEn;
    logic [A-1:0]    IssueRegister;
    logic [D-1:0]    Busy;
    logic [A:0]      BusyCount;
    logic            WriteUnexpected;

    regfile_mp #(
        .WIDTH   (W),
        .DEPTH   (D),
        .NUM_RD  (NR),
        .HAS_ZERO(1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .RegWrite       (RegWrite),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .ReadRegister   (ReadRegister),
        .ReadData       (ReadData),
        .IssueEn        (IssueEn),
        .IssueRegister  (IssueRegister),
        .Busy           (Busy),
        .BusyCount      (BusyCount),
        .WriteUnexpected(WriteUnexpected)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;  // 0 read port, 1 Busy, 2 BusyCount, 3 WriteUnexpected
        int          idx;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] model [D];

    function automatic logic [63:0] observe(int kind, int idx);
        case (kind)
            0:       return ReadData[idx*W +: W];
            1:       return {32'b0, Busy};
            2:       return {58'b0, BusyCount};
            default: return {63'b0, WriteUnexpected};
        endcase
    endfunction

    task automatic expect_val(string tag, int kind, int idx, logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [63:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.kind, e.idx);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(int p, logic [A-1:0] addr);
        ReadRegister[p*A +: A] = addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] wd;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister = '0; IssueEn = 1'b0; IssueRegister = '0;
        for (int i = 0; i < D; i++) model[i] = '0;
        tick(); tick();
        reset = 1'b0;

        // 1: write then reset clears everything
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEAD; set_rd(0, 5'd5);
        tick();
        RegWrite = 1'b0;
        expect_val("pre_reset_rd5", 0, 0, 64'hDEAD);
        expect_val("pre_reset_unexp", 3, 0, 64'd1);
        check_all();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        expect_val("reset_rd5", 0, 0, 64'd0);
        expect_val("reset_busy", 1, 0, 64'd0);
        expect_val("reset_cnt", 2, 0, 64'd0);
        expect_val("reset_unexp", 3, 0, 64'd0);
        check_all();

        // 2: zero register ignores writes
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hA0; set_rd(0, 5'd31);
        tick();
        RegWrite = 1'b0;
        expect_val("zero_rd", 0, 0, 64'd0);
        expect_val("zero_unexp", 3, 0, 64'd0);
        expect_val("zero_busy", 1, 0, 64'd0);
        check_all();

        // 3: fill registers, check write-cycle and post-edge reads
        for (int i = 0; i < D - 1; i++) begin
            wd = 64'(i) * 64'h0000010204080001;
            RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = wd;
            set_rd(0, 5'(i)); set_rd(1, 5'(i)); set_rd(2, (i == 0) ? 5'd31 : 5'(i - 1));
            #1;
`ifdef REGFILE_BYPASS_EN
            expect_val("wcycle_rd", 0, 0, wd);
`else
            expect_val("wcycle_rd", 0, 0, model[i]);
`endif
            check_all();
            expect_val("fill_rd_p0", 0, 0, wd);
            expect_val("fill_rd_p1", 0, 1, wd);
            expect_val("fill_rd_p2", 0, 2, (i == 0) ? 64'd0 : model[i-1]);
            tick();
            model[i] = wd;
            check_all();
        end
        RegWrite = 1'b0;

        // 4: issue to 3 and 7, then retire 3
        IssueEn = 1'b1; IssueRegister = 5'd3;
        tick();
        IssueRegister = 5'd7;
        tick();
        IssueEn = 1'b0;
        expect_val("issue_busy", 1, 0, 64'h88);
        expect_val("issue_cnt", 2, 0, 64'd2);
        check_all();
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h33; set_rd(0, 5'd3);
        tick();
        RegWrite = 1'b0;
        expect_val("retire_busy", 1, 0, 64'h80);
        expect_val("retire_cnt", 2, 0, 64'd1);
        expect_val("retire_unexp", 3, 0, 64'd0);
        expect_val("retire_rd3", 0, 0, 64'h33);
        check_all();

        // 5: issue and write to busy reg 7 together -> stays busy
        IssueEn = 1'b1; IssueRegister = 5'd7;
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h77; set_rd(1, 5'd7);
        tick();
        IssueEn = 1'b0; RegWrite = 1'b0;
        expect_val("both_busy", 1, 0, 64'h80);
        expect_val("both_cnt", 2, 0, 64'd1);
        expect_val("both_rd7", 0, 1, 64'h77);
        expect_val("both_unexp", 3, 0, 64'd0);
        check_all();

        // 6: unexpected write pulses for one cycle
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h99; set_rd(2, 5'd9);
        tick();
        RegWrite = 1'b0;
        expect_val("unexp_pulse", 3, 0, 64'd1);
        expect_val("unexp_rd9", 0, 2, 64'h99);
        expect_val("unexp_busy", 1, 0, 64'h80);
        expect_val("unexp_cnt", 2, 0, 64'd1);
        check_all();
        tick();
        expect_val("unexp_drop", 3, 0, 64'd0);
        check_all();

        // reset wins over simultaneous issue
        reset = 1'b1; IssueEn = 1'b1; IssueRegister = 5'd4;
        tick();
        reset = 1'b0; IssueEn = 1'b0;
        expect_val("rst_issue_busy", 1, 0, 64'd0);
        expect_val("rst_issue_cnt", 2, 0, 64'd0);
        expect_val("rst_rd9", 0, 2, 64'd0);
        check_all();
        tick();
        expect_val("rst_issue_busy2", 1, 0, 64'd0);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file. It is the successor to the fixed 32x64, 2-read-port register file. It adds:
- configurable width, depth and read-port count;
- synchronous reset that clears all registers;
- a per-register busy scoreboard with an outstanding-producer counter, which the pipeline's hazard/stall logic uses.

It sits between decode (issue side) and writeback (write side) of the datapath.

Parameters:
WIDTH, 64, data bits per register
DEPTH, 32, number of registers; power of two, >= 2
NUM_RD, 2, number of asynchronous read ports, >= 1
AW, $clog2(DEPTH), address width (derived, not overridden)
HAS_ZERO, 1, 1 = register DEPTH-1 is hardwired zero; 0 = all registers writable

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous, active-high reset
RegWrite  input  1  write enable
WriteRegister  input  AW  write address
WriteData  input  WIDTH  write data
ReadRegister  input  NUM_RD*AW  read addresses, port p at [p*AW +: AW]
ReadData  output  NUM_RD*WIDTH  read data, port p at [p*WIDTH +: WIDTH]
IssueEn  input  1  mark IssueRegister as pending (producer issued)
IssueRegister  input  AW  destination register of the issued instruction
Busy  output  DEPTH  per-register pending flag
BusyCount  output  AW+1  number of set Busy bits
WriteUnexpected  output  1  one-cycle pulse: write to a register that was not busy

Behaviour:
- Clocking: one clock clk. Reset is synchronous and active-high, named reset. All state updates on the rising edge of clk.
- Reset (reset=1 at edge):
  - all registers = 0, Busy = 0, BusyCount = 0, WriteUnexpected = 0;
  - RegWrite and IssueEn are ignored that cycle;
  - reset mid-operation discards pending writes and clears the scoreboard immediately.
- Write: if RegWrite=1, the register at WriteRegister takes WriteData at the edge.
  - HAS_ZERO=1 and WriteRegister=DEPTH-1: write is ignored; the register stays 0.
- Read: combinational. ReadData[p] = reg[ReadRegister[p]].
  - Zero register always reads 0.
  - Default build: a same-cycle write is visible on reads only after the edge (see Optional Feature for bypass).
- Scoreboard, per register r, at each non-reset edge:
  - set = IssueEn && IssueRegister==r; clr = RegWrite && WriteRegister==r.
  - set=1: Busy[r] becomes 1. Issue wins over a simultaneous write, because a new producer supersedes the old one.
  - set=0, clr=1: Busy[r] becomes 0.
  - Otherwise Busy[r] holds.
  - With HAS_ZERO=1, Busy[DEPTH-1] is constant 0 and issue to it is ignored.
- BusyCount: registered. It is updated in the same edge as Busy and always equals popcount(Busy). Next-state rule: +1 on a net set, -1 on a net clear, unchanged otherwise. It never wraps; the maximum is DEPTH (DEPTH-1 when HAS_ZERO).
- WriteUnexpected: registered, 1 for exactly the cycle after an edge at which RegWrite=1, WriteRegister was writable, and Busy[WriteRegister]=0 before the edge. It is 0 otherwise, including for zero-register writes. The data write still occurs.
- Read latency 0. Write-to-read latency 1 edge. Issue-to-Busy latency 1 edge.

Optional Feature:
Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding on every read port. If RegWrite=1, WriteRegister==ReadRegister[p], and the register is writable, then ReadData[p] = WriteData in the same cycle. The zero register still reads 0.
- Undefined: no forwarding. ReadData[p] shows the pre-edge register contents during the write cycle.
- Scoreboard behaviour is identical in both builds.

Test Plan:
1. Assert reset for 2 cycles after writing 0xDEAD to reg 5 -> ReadData on port reading reg 5 = 0; Busy=0; BusyCount=0.
2. RegWrite=1, WriteRegister=31, WriteData=0xA0 (HAS_ZERO=1) -> reg 31 reads 0; WriteUnexpected stays 0; Busy[31] stays 0.
3. For i=0..30, write i*64'h0000010204080001 -> all NUM_RD=3 ports read back the correct values in the following cycle. With REGFILE_BYPASS_EN, the read of i in the write cycle already shows the new value; without it, the old value.
4. IssueEn with IssueRegister=3, then 7 -> Busy[3]=Busy[7]=1, BusyCount=2. Then write reg 3 -> Busy[3]=0, BusyCount=1, WriteUnexpected=0.
5. Same cycle: IssueEn to reg 7 and RegWrite to reg 7 with Busy[7]=1 -> Busy[7] stays 1, BusyCount unchanged, data updated.
6. Write reg 9 while Busy[9]=0 -> WriteUnexpected=1 for exactly one cycle, reg 9 updated. Assert reset in the same cycle as IssueEn to reg 4 -> Busy[4]=0 afterward.
